ram_tp_be_bypass: RTL and testbench
===================================

RAM_TP_BE_BYPASS -- requirements
Module: ram_tp_be_bypass

Interface
REQ-001 SHALL have parameter ADR_WD, default 5, address width; depth is 2^ADR_WD words.
REQ-002 SHALL have parameter DAT_WD, default 64, word width in bits.
REQ-003 SHALL have parameter COL_WD, default 8, write-enable column width in bits; DAT_WD SHALL be an integer multiple of COL_WD; NCOL = DAT_WD/COL_WD.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 wr_ena_i  input  NCOL  per-column write enable, high active; all-zero means no write.
REQ-007 wr_adr_i  input  ADR_WD  write address.
REQ-008 wr_dat_i  input  DAT_WD  write data.
REQ-009 rd_ena_i  input  1  read request, high active.
REQ-010 rd_adr_i  input  ADR_WD  read address.
REQ-011 rd_dat_o  output  DAT_WD  read data, registered.
REQ-012 rd_val_o  output  1  rd_dat_o carries the result of a read issued the previous cycle.
REQ-013 init_done_o  output  1  high once the clear sweep has completed; stays high until next reset.

Function
REQ-014 SHALL implement a two-state FSM: INIT and READY; reset enters INIT.
REQ-015 In INIT, an ADR_WD-bit counter SHALL step 0 to 2^ADR_WD-1, one address per cycle, writing all-zero to every column.
REQ-016 INIT SHALL last exactly 2^ADR_WD cycles; the FSM SHALL move to READY on the cycle after address 2^ADR_WD-1 is written, and init_done_o SHALL be high from that cycle onward.
REQ-017 In INIT, wr_ena_i and rd_ena_i SHALL be ignored; memory is not user-written and rd_val_o stays 0.
REQ-018 In READY, for each column c with wr_ena_i[c]=1, bits [c*COL_WD +: COL_WD] of word wr_adr_i SHALL be replaced by the same bits of wr_dat_i; columns with enable 0 SHALL be unchanged.
REQ-019 In READY, rd_ena_i=1 SHALL produce the word at rd_adr_i on rd_dat_o with rd_val_o=1 on the next cycle (latency 1).
REQ-020 A cycle with rd_ena_i=0 SHALL give rd_val_o=0 on the next cycle; rd_dat_o SHALL hold its previous value.
REQ-021 Read and write on different addresses in the same cycle SHALL both complete with no interaction.
REQ-022 Read and write on the same address in the same cycle (collision) SHALL resolve per REQ-027/REQ-028; the write SHALL always complete.
REQ-023 Back-to-back reads every cycle SHALL be supported at full throughput.

Reset
REQ-024 With rst=1 at a clock edge: rd_dat_o=0, rd_val_o=0, init_done_o=0, sweep counter=0, FSM=INIT.
REQ-025 Reset asserted mid-INIT or in READY SHALL abort any operation and restart the full sweep from address 0 once rst falls.
REQ-026 Memory contents SHALL NOT be reset directly; only the sweep clears them.

Configuration
REQ-027 With macro RAM_BYPASS_EN defined, a collision read SHALL return, per column, wr_dat_i where wr_ena_i[c]=1 and the old stored data where wr_ena_i[c]=0 (write-first forwarding).
REQ-028 Without RAM_BYPASS_EN, a collision read SHALL return the complete old stored word (read-first); no forwarding logic SHALL be built.

Verification (defaults ADR_WD=5, DAT_WD=64, COL_WD=8)
REQ-029 rst high 2 cycles then low -> init_done_o rises exactly 32 cycles later; then read addr 31 -> rd_dat_o=0, rd_val_o=1 one cycle after.
REQ-030 Write addr 3 data 0x1122334455667788 ena 8'hFF, then addr 3 data 0xAAAAAAAAAAAAAAAA ena 8'h0F, then read addr 3 -> 0x11223344AAAAAAAA.
REQ-031 After REQ-030, same-cycle write addr 3 data 0xFFFFFFFFFFFFFFFF ena 8'hF0 and read addr 3 -> with RAM_BYPASS_EN 0xFFFFFFFFAAAAAAAA; without it 0x11223344AAAAAAAA; next read addr 3 -> 0xFFFFFFFFAAAAAAAA in both builds.
REQ-032 Assert write ena 8'hFF data 0x5 addr 7 and read addr 7 during INIT -> rd_val_o stays 0; after init_done_o, read addr 7 -> 0.
REQ-033 Write addr 9 in READY, assert rst for 1 cycle at sweep counter 10 of a second INIT -> init_done_o rises 32 cycles after rst falls; read addr 9 -> 0.

Source files
------------

// File: rtl/ram_tp_be_bypass.sv
// ram_tp_be_bypass: two-port (1W/1R) RAM with per-column write enables and a power-up clear sweep.
// The sweep zeroes every word after reset. Reads are registered and take one cycle.
// Optional macro RAM_BYPASS_EN: a read and a write to the same address in the same cycle
// return write-first data, forwarded per column. Without the macro such a read returns the
// old stored word.
module ram_tp_be_bypass #(
  parameter int unsigned ADR_WD = 5,
  parameter int unsigned DAT_WD = 64,
  parameter int unsigned COL_WD = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DAT_WD/COL_WD-1:0]   wr_ena_i,
  input  logic [ADR_WD-1:0]          wr_adr_i,
  input  logic [DAT_WD-1:0]          wr_dat_i,
  input  logic                       rd_ena_i,
  input  logic [ADR_WD-1:0]          rd_adr_i,
  output logic [DAT_WD-1:0]          rd_dat_o,
  output logic                       rd_val_o,
  output logic                       init_done_o
);

  localparam int unsigned NCOL  = DAT_WD / COL_WD;
  localparam int unsigned DEPTH = 1 << ADR_WD;

  if ((DAT_WD % COL_WD) != 0) begin : g_bad_col_wd
    $error("DAT_WD must be an integer multiple of COL_WD");
  end

  typedef enum logic {
    S_INIT  = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADR_WD-1:0]   r_cnt;
  logic [DAT_WD-1:0]   r_mem [DEPTH];
  logic [DAT_WD-1:0]   r_rd_dat;
  logic                r_rd_val;
  logic                r_init_done;

  logic [NCOL-1:0]     w_mem_col;
  logic [ADR_WD-1:0]   w_mem_adr;
  logic [DAT_WD-1:0]   w_mem_dat;
  logic                w_rd_fire;
  logic                w_cnt_ena;
  logic [DAT_WD-1:0]   w_rd_word;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: leave INIT once the last address has been cleared
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT:  if (&r_cnt) w_state_nxt = S_READY;
      S_READY: w_state_nxt = S_READY;
      default: w_state_nxt = S_INIT;
    endcase
  end

  // FSM outputs: sweep writes zeros in INIT, user ports are honoured only in READY
  always_comb begin
    w_mem_col = '0;
    w_mem_adr = wr_adr_i;
    w_mem_dat = wr_dat_i;
    w_rd_fire = 1'b0;
    w_cnt_ena = 1'b0;
    case (r_state)
      S_INIT: begin
        w_mem_col = {NCOL{~rst}};
        w_mem_adr = r_cnt;
        w_mem_dat = '0;
        w_cnt_ena = 1'b1;
      end
      S_READY: begin
        w_mem_col = wr_ena_i & {NCOL{~rst}};
        w_rd_fire = rd_ena_i & ~rst;
      end
      default: ;
    endcase
  end

  // Sweep address counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_cnt_ena) begin
      r_cnt <= ADR_WD'(r_cnt + 1'b1);
    end
  end

  // Storage array with per-column write enables; contents are never reset
  always_ff @(posedge clk) begin
    for (int c = 0; c < int'(NCOL); c++) begin
      if (w_mem_col[c]) begin
        r_mem[w_mem_adr][c*COL_WD +: COL_WD] <= w_mem_dat[c*COL_WD +: COL_WD];
      end
    end
  end

`ifdef RAM_BYPASS_EN
  // Read word with write-first forwarding of enabled columns on an address collision
  always_comb begin
    w_rd_word = r_mem[rd_adr_i];
    for (int c = 0; c < int'(NCOL); c++) begin
      if (wr_ena_i[c] && (wr_adr_i == rd_adr_i) && (r_state == S_READY)) begin
        w_rd_word[c*COL_WD +: COL_WD] = wr_dat_i[c*COL_WD +: COL_WD];
      end
    end
  end
`else
  // Read word: stored contents before this cycle's write (read-first)
  always_comb begin
    w_rd_word = r_mem[rd_adr_i];
  end
`endif

  // Registered read port; data holds when no read was issued
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_dat <= '0;
      r_rd_val <= 1'b0;
    end else begin
      r_rd_val <= w_rd_fire;
      if (w_rd_fire) begin
        r_rd_dat <= w_rd_word;
      end
    end
  end

  // Sticky init-done flag, set on the cycle the FSM enters READY
  always_ff @(posedge clk) begin
    if (rst) begin
      r_init_done <= 1'b0;
    end else if (w_state_nxt == S_READY) begin
      r_init_done <= 1'b1;
    end
  end

  assign rd_dat_o    = r_rd_dat;
  assign rd_val_o    = r_rd_val;
  assign init_done_o = r_init_done;

endmodule

// File: tb/tb_ram_tp_be_bypass.sv
// Self-checking bench for ram_tp_be_bypass (default parameters).
// A bench-side memory model predicts read data. Predictions are queued when a read is issued
// and popped when rd_val_o is due. Define RAM_BYPASS_EN for both the bench and the RTL to
// check the write-first build.
module tb_ram_tp_be_bypass;

  localparam int unsigned ADR_WD = 5;
  localparam int unsigned DAT_WD = 64;
  localparam int unsigned COL_WD = 8;
  localparam int unsigned NCOL   = DAT_WD / COL_WD;
  localparam int unsigned DEPTH  = 1 << ADR_WD;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCOL-1:0]   wr_ena_i = '0;
  logic [ADR_WD-1:0] wr_adr_i = '0;
  logic [DAT_WD-1:0] wr_dat_i = '0;
  logic              rd_ena_i = 1'b0;
  logic [ADR_WD-1:0] rd_adr_i = '0;
  logic [DAT_WD-1:0] rd_dat_o;
  logic              rd_val_o;
  logic              init_done_o;

  ram_tp_be_bypass #(.ADR_WD(ADR_WD), .DAT_WD(DAT_WD), .COL_WD(COL_WD)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .wr_ena_i    (wr_ena_i),
    .wr_adr_i    (wr_adr_i),
    .wr_dat_i    (wr_dat_i),
    .rd_ena_i    (rd_ena_i),
    .rd_adr_i    (rd_adr_i),
    .rd_dat_o    (rd_dat_o),
    .rd_val_o    (rd_val_o),
    .init_done_o (init_done_o)
  );

  always #5 clk = ~clk;

  int unsigned       n_chk = 0;
  int unsigned       n_err = 0;
  logic [DAT_WD-1:0] mdl_mem [DEPTH];
  int unsigned       mdl_cnt = 0;
  logic [DAT_WD-1:0] exp_q [$];
  logic [DAT_WD-1:0] exp_dat = '0;

  task automatic chk(input string tag, input logic [DAT_WD-1:0] obs, input logic [DAT_WD-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=0x%0h required=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, update model, then check outputs after the edge
  task automatic step(input logic rst_v, input logic [NCOL-1:0] wena, input logic [ADR_WD-1:0] wadr,
                      input logic [DAT_WD-1:0] wdat, input logic rena, input logic [ADR_WD-1:0] radr);
    logic              ready;
    logic              exp_val;
    logic [DAT_WD-1:0] word;
    logic [DAT_WD-1:0] mask;
    rst = rst_v; wr_ena_i = wena; wr_adr_i = wadr; wr_dat_i = wdat;
    rd_ena_i = rena; rd_adr_i = radr;
    ready   = !rst_v && (mdl_cnt >= DEPTH);
    exp_val = ready && rena;
    mask    = '0;
    for (int c = 0; c < int'(NCOL); c++) begin
      if (wena[c]) mask[c*COL_WD +: COL_WD] = '1;
    end
    if (exp_val) begin
      word = mdl_mem[radr];
`ifdef RAM_BYPASS_EN
      if (wadr == radr) word = (word & ~mask) | (wdat & mask);
`endif
      exp_q.push_back(word);
    end
    if (ready) begin
      mdl_mem[wadr] = (mdl_mem[wadr] & ~mask) | (wdat & mask);
    end else if (!rst_v) begin
      mdl_mem[mdl_cnt[ADR_WD-1:0]] = '0;
    end
    if (rst_v) mdl_cnt = 0;
    else if (mdl_cnt < DEPTH) mdl_cnt++;
    @(posedge clk);
    #1;
    chk("rd_val", DAT_WD'(rd_val_o), DAT_WD'(exp_val));
    chk("init_done", DAT_WD'(init_done_o), DAT_WD'(mdl_cnt >= DEPTH));
    if (rst_v) begin
      exp_dat = '0;
      exp_q.delete();
    end else if (exp_val) begin
      if (exp_q.size() == 0) chk("queue_empty", 64'd1, 64'd0);
      else exp_dat = exp_q.pop_front();
    end
    chk("rd_dat", rd_dat_o, exp_dat);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic rd(input logic [ADR_WD-1:0] a);
    step(1'b0, '0, '0, '0, 1'b1, a);
  endtask

  task automatic wr(input logic [ADR_WD-1:0] a, input logic [DAT_WD-1:0] d, input logic [NCOL-1:0] e);
    step(1'b0, e, a, d, 1'b0, '0);
  endtask

  initial begin
    // Reset two cycles, then the sweep with user writes/reads that must be ignored
    step(1'b1, '0, '0, '0, 1'b0, '0);
    step(1'b1, '0, '0, '0, 1'b0, '0);
    for (int i = 0; i < int'(DEPTH); i++) step(1'b0, 8'hFF, 5'd7, 64'h5, 1'b1, 5'd7);
    rd(5'd31);
    rd(5'd7);

    // Byte-enable writes and a read back
    wr(5'd3, 64'h1122334455667788, 8'hFF);
    wr(5'd3, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    rd(5'd3);
    chk("be_merge", exp_dat, 64'h11223344AAAAAAAA);

    // Collision, then read back in both builds
    step(1'b0, 8'hF0, 5'd3, 64'hFFFFFFFFFFFFFFFF, 1'b1, 5'd3);
`ifdef RAM_BYPASS_EN
    chk("collision", rd_dat_o, 64'hFFFFFFFFAAAAAAAA);
`else
    chk("collision", rd_dat_o, 64'h11223344AAAAAAAA);
`endif
    rd(5'd3);
    chk("after_collision", rd_dat_o, 64'hFFFFFFFFAAAAAAAA);

    // Different-address read/write in the same cycle
    step(1'b0, 8'hFF, 5'd4, 64'hDEADBEEFCAFEF00D, 1'b1, 5'd3);
    rd(5'd4);

    // Random traffic on a narrow address range: back-to-back reads and frequent collisions
    for (int i = 0; i < 60; i++) begin
      step(1'b0, NCOL'($urandom), ADR_WD'($urandom_range(0, 3)), {$urandom, $urandom},
           1'($urandom_range(0, 3) != 0), ADR_WD'($urandom_range(0, 3)));
    end
    idle(2);

    // Reset in READY, then reset again at sweep counter 10 of the second INIT
    wr(5'd9, 64'h0123456789ABCDEF, 8'hFF);
    rd(5'd9);
    step(1'b1, '0, '0, '0, 1'b0, '0);
    idle(10);
    step(1'b1, 8'hFF, 5'd9, 64'h1, 1'b1, 5'd9);
    idle(int'(DEPTH));
    rd(5'd9);
    chk("cleared_after_rerun", rd_dat_o, 64'd0);
    rd(5'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
